// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared widths, payload layout and FSM encoding for the MEM stage
// Contents:
//   TO_MEM_W / TO_WB_W / FWD_W : EX->MEM payload, MEM->WB payload, forward bus widths
//                                (MEM_forward is FWD_W+1 bits).
//   mem_payload_t              : field layout of to_MEM_data, MSB first.
//   mem_state_e                : data_ok handshake FSM states.
package mem_stage_pkg;
  localparam int TO_MEM_W = 136;
  localparam int TO_WB_W  = 164;
  localparam int FWD_W    = 38;
  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_WAIT,
    MEM_HOLD,
    MEM_DISCARD
  } mem_state_e;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu_result;
    logic        rd1;
    logic        rd2;
    logic        rd4;
    logic        rd_signed;
    logic [4:0]  dest;
    logic        gr_we;
    logic        ex_int;
    logic        ex_sys;
    logic        ex_brk;
    logic        ex_adef;
    logic        ex_ale;
    logic        ex_ine;
    logic        is_ertn;
    logic        op_csr;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [4:0]  rj;
    logic        rdcntvh;
    logic        rdcntvl;
    logic        rdcntid;
  } mem_payload_t;
  function automatic logic [5:0] ex_bits(mem_payload_t p);
    return {p.ex_int, p.ex_sys, p.ex_brk, p.ex_adef, p.ex_ale, p.ex_ine};
  endfunction
endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: extract and sign/zero-extend load data from a 32-bit SRAM word
// Ports:
//   rdata_i    : raw 32-bit word from the data SRAM
//   addr_low_i : low two address bits selecting the byte/halfword lane
//   byte_i     : byte load (ld.b / ld.bu)
//   half_i     : halfword load (ld.h / ld.hu); neither set means full word
//   signed_i   : sign-extend the extracted value, else zero-extend
//   data_o     : aligned, extended 32-bit result
module mem_load_align (
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_low_i,
  input  logic        byte_i,
  input  logic        half_i,
  input  logic        signed_i,
  output logic [31:0] data_o
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = rdata_i[{addr_low_i, 3'b000} +: 8];
  assign h = addr_low_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  assign data_o = byte_i ? {{24{signed_i & b[7]}}, b}
                : half_i ? {{16{signed_i & h[15]}}, h}
                : rdata_i;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between EX and write-back
// Holds the instruction whose data SRAM request EX issued, aligns and extends
// load data, selects the write-back value and drives the MEM forward bus to ID.
// Ports:
//   clk, reset (synchronous, active-high), csr_reset (pipeline flush)
//   EX_to_MEM_valid, to_MEM_data, EX_mem_req : from EX; MEM_allow_in : to EX
//   MEM_to_WB_valid, to_WB_data : to WB; WB_allow_in : from WB
//   data_sram_rdata, data_sram_data_ok : data SRAM response
//   mem_ex      : excepting instruction (or ertn) resident in MEM, to EX
//   MEM_forward : {MEM_dest, final_result, MEM_load_pending, MEM_op_csr} to ID
// Configuration:
//   MEM_DATA_OK_HANDSHAKE_EN defined   : variable-latency data_ok handshake with
//                                        response buffer and discard of flushed replies.
//   MEM_DATA_OK_HANDSHAKE_EN undefined : fixed one-cycle SRAM, data_ok ignored.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                csr_reset,
  input  logic                EX_to_MEM_valid,
  input  logic [TO_MEM_W-1:0] to_MEM_data,
  input  logic                EX_mem_req,
  output logic                MEM_allow_in,
  input  logic                WB_allow_in,
  output logic                MEM_to_WB_valid,
  output logic [TO_WB_W-1:0]  to_WB_data,
  input  logic [31:0]         data_sram_rdata,
  input  logic                data_sram_data_ok,
  output logic                mem_ex,
  output logic [FWD_W:0]      MEM_forward
);
  mem_payload_t payload_q;
  logic         valid_q, valid_d, req_q, take;
  logic         ready_go, load_pending, is_load;
  logic [31:0]  ld_rdata, ld_data, final_result;
  assign is_load = payload_q.rd1 | payload_q.rd2 | payload_q.rd4;
  assign take    = EX_to_MEM_valid & MEM_allow_in;
  assign valid_d = MEM_allow_in ? EX_to_MEM_valid : valid_q;
  always_ff @(posedge clk) begin
    valid_q <= (reset | csr_reset) ? 1'b0 : valid_d;
    if (reset) req_q <= 1'b0;
    else if (take) req_q <= EX_mem_req;
    if (take) payload_q <= to_MEM_data;
  end
`ifdef MEM_DATA_OK_HANDSHAKE_EN
  mem_state_e  state_q, state_d;
  logic [31:0] buf_q, buf_d;
  always_ff @(posedge clk) begin
    state_q <= reset ? MEM_IDLE : state_d;
    buf_q   <= buf_d;
  end
  // A flush while a reply is owed leaves a stray data_ok in flight; DISCARD
  // swallows it so the next request is not matched with the old reply.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    if (csr_reset)
      state_d = ((state_q == MEM_WAIT) || (state_q == MEM_DISCARD)) && !data_sram_data_ok
              ? MEM_DISCARD : MEM_IDLE;
    else if (state_q == MEM_DISCARD)
      state_d = data_sram_data_ok ? MEM_IDLE : MEM_DISCARD;
    else if (MEM_allow_in)
      state_d = (take && EX_mem_req) ? MEM_WAIT : MEM_IDLE;
    else if ((state_q == MEM_WAIT) && data_sram_data_ok) begin
      state_d = MEM_HOLD;
      buf_d   = data_sram_rdata;
    end
  end
  assign ready_go     = ~req_q | (state_q == MEM_HOLD) | ((state_q == MEM_WAIT) & data_sram_data_ok);
  assign ld_rdata     = (state_q == MEM_HOLD) ? buf_q : data_sram_rdata;
  assign load_pending = valid_q & is_load & ~ready_go;
  assign MEM_allow_in = (state_q != MEM_DISCARD) & (~valid_q | (ready_go & WB_allow_in));
`else
  // The synchronous SRAM keeps rdata stable while MEM stalls, so no buffer.
  logic unused_data_ok;
  assign unused_data_ok = data_sram_data_ok;
  assign ready_go       = 1'b1;
  assign ld_rdata       = data_sram_rdata;
  assign load_pending   = 1'b0;
  assign MEM_allow_in   = ~valid_q | WB_allow_in;
`endif
  mem_load_align u_align (
    .rdata_i    (ld_rdata),
    .addr_low_i (payload_q.alu_result[1:0]),
    .byte_i     (payload_q.rd1),
    .half_i     (payload_q.rd2),
    .signed_i   (payload_q.rd_signed),
    .data_o     (ld_data)
  );
  // An excepting load never issued (req_q=0) reports its address instead.
  assign final_result    = (is_load & req_q) ? ld_data : payload_q.alu_result;
  assign MEM_to_WB_valid = valid_q & ready_go;
  assign mem_ex          = valid_q & (|ex_bits(payload_q) | payload_q.is_ertn);
  assign to_WB_data = {payload_q.pc, final_result, payload_q.dest, payload_q.gr_we,
                       ex_bits(payload_q), payload_q.is_ertn, payload_q.op_csr,
                       payload_q.csr_num, payload_q.csr_wmask, payload_q.rj,
                       payload_q.rdcntvh, payload_q.rdcntvl, payload_q.rdcntid,
                       payload_q.alu_result};
  assign MEM_forward = {payload_q.dest & {5{valid_q}}, final_result, load_pending,
                        payload_q.op_csr & valid_q};
endmodule
